// File: rtl/tt_sweeper.sv
// tt_sweeper: sweeps all 2^N_IN input patterns through an attached Boolean
// function and captures its truth table and onset count, handing the result
// to the back end over a valid/ready handshake.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   start       sweep request, honoured only in IDLE
//   busy        sweep in progress (start accepted, result not yet valid)
//   x, x_valid  pattern driven to the function and its qualifier
//   f_in        function output for the pattern applied FN_LAT cycles earlier
//   tt, onset   captured truth table (tt[k] = f(k)) and its popcount
//   tt_valid    result valid; held until tt_ready is seen
//   tt_ready    consumer accepts the result
module tt_sweeper #(
  parameter int unsigned N_IN   = 7,
  parameter int unsigned FN_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic [N_IN-1:0]         x,
  output logic                    x_valid,
  input  logic                    f_in,
  output logic [(1 << N_IN)-1:0]  tt,
  output logic [N_IN:0]           onset,
  output logic                    tt_valid,
  input  logic                    tt_ready
);

  localparam int unsigned TT_W = 1 << N_IN;
  localparam int unsigned ON_W = N_IN + 1;
  localparam logic [N_IN-1:0] X_LAST = N_IN'(TT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_e;

  state_e            state_q;
  logic [N_IN-1:0]   x_q;
  logic              x_valid_q;
  logic              busy_q;
  logic              tt_valid_q;
  logic [TT_W-1:0]   tt_q;
  logic [ON_W-1:0]   onset_q;

  // Pattern and qualifier realigned with f_in
  logic              cap_v;
  logic [N_IN-1:0]   cap_x;

  // Delay line matching the attached function's pipeline depth
  generate
    if (FN_LAT == 0) begin : g_comb
      assign cap_v = x_valid_q;
      assign cap_x = x_q;
    end else begin : g_pipe
      logic [FN_LAT-1:0] dv_q;
      logic [N_IN-1:0]   dx_q [FN_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dv_q <= '0;
          for (int i = 0; i < int'(FN_LAT); i++) dx_q[i] <= '0;
        end else begin
          dv_q[0] <= x_valid_q;
          dx_q[0] <= x_q;
          for (int i = 1; i < int'(FN_LAT); i++) begin
            dv_q[i] <= dv_q[i-1];
            dx_q[i] <= dx_q[i-1];
          end
        end
      end

      assign cap_v = dv_q[FN_LAT-1];
      assign cap_x = dx_q[FN_LAT-1];
    end
  endgenerate

  // Sweep control, capture and result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      x_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      tt_valid_q <= 1'b0;
      tt_q       <= '0;
      onset_q    <= '0;
    end else begin
      // Bits are written by index so capture order never matters
      if (cap_v) begin
        tt_q[cap_x] <= f_in;
        onset_q     <= onset_q + ON_W'(f_in);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_SWEEP;
            x_q       <= '0;
            x_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            tt_q      <= '0;
            onset_q   <= '0;
          end
        end
        S_SWEEP: begin
          if (x_q == X_LAST) begin
            x_q       <= '0;
            x_valid_q <= 1'b0;
            if (FN_LAT == 0) begin
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              tt_valid_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            x_q <= x_q + N_IN'(1);
          end
        end
        S_DRAIN: begin
          // Leave on the edge that captures the final pattern
          if (cap_v && (cap_x == X_LAST)) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            tt_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (tt_ready) begin
            state_q    <= S_IDLE;
            tt_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign busy     = busy_q;
  assign tt_valid = tt_valid_q;
  assign tt       = tt_q;
  assign onset    = onset_q;

endmodule

// File: tb/tb_tt_sweeper.sv
// Bench for tt_sweeper: default instance (7 inputs, combinational function)
// driven from a bench-held function table, plus a 3-input instance fed by
// a two-register majority function.
module tb_tt_sweeper;

  localparam int unsigned TW = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, tt_ready, f_in;
  logic         busy, x_valid, tt_valid;
  logic [6:0]   x;
  logic [127:0] tt;
  logic [7:0]   onset;

  logic [127:0] fn_tt;
  logic         force_en, force_val;

  logic         start2, rdy2, f2, busy2, xv2, ttv2;
  logic [2:0]   x2;
  logic [7:0]   tt2;
  logic [3:0]   on2;
  logic         m1, m2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign f_in = force_en ? force_val : fn_tt[x];

  always_ff @(posedge clk) begin
    m1 <= (x2[0] & x2[1]) | (x2[0] & x2[2]) | (x2[1] & x2[2]);
    m2 <= m1;
  end
  assign f2 = m2;

  tt_sweeper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .x(x),
    .x_valid(x_valid), .f_in(f_in), .tt(tt), .onset(onset),
    .tt_valid(tt_valid), .tt_ready(tt_ready)
  );

  tt_sweeper #(.N_IN(3), .FN_LAT(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .x(x2),
    .x_valid(xv2), .f_in(f2), .tt(tt2), .onset(on2),
    .tt_valid(ttv2), .tt_ready(rdy2)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_tt(input int fid, input logic [127:0] rnd);
    logic [127:0] t;
    t = '0;
    for (int k = 0; k < int'(TW); k++) begin
      case (fid)
        0:       t[k] = k[0];
        1:       t[k] = (k == 127);
        2:       t[k] = 1'b1;
        3:       t[k] = k[6];
        default: t[k] = rnd[k];
      endcase
    end
    return t;
  endfunction

  function automatic int popc(input logic [127:0] v);
    int n;
    n = 0;
    for (int k = 0; k < int'(TW); k++) n += int'(v[k]);
    return n;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Launch one sweep and follow it until tt_valid, checking timing and result
  task automatic run_sweep(input string tag, input logic [127:0] exp_tt,
                           input int exp_on, input bit accept);
    int e, nxv;
    bit seq_ok, busy_ok;
    e = 0; nxv = 0; seq_ok = 1'b1; busy_ok = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    while (tt_valid !== 1'b1 && e < 400) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (x_valid === 1'b1) begin
        if (x !== 7'(nxv)) seq_ok = 1'b0;
        nxv++;
      end else if (x !== 7'd0) begin
        seq_ok = 1'b0;
      end
      @(negedge clk);
      e++;
    end
    chk({tag, "_latency"}, 128'(e), 128'(TW));
    chk({tag, "_xvalid_cycles"}, 128'(nxv), 128'(TW));
    chk({tag, "_x_sequence"}, 128'(seq_ok), 128'd1);
    chk({tag, "_busy_during"}, 128'(busy_ok), 128'd1);
    chk({tag, "_tt"}, tt, exp_tt);
    chk({tag, "_onset"}, 128'(onset), 128'(exp_on));
    chk({tag, "_busy_done"}, 128'(busy), 128'd0);
    if (accept) begin
      tt_ready = 1'b1;
      @(negedge clk);
      tt_ready = 1'b0;
      chk({tag, "_valid_drop"}, 128'(tt_valid), 128'd0);
      chk({tag, "_tt_held"}, tt, exp_tt);
    end
  endtask

  initial begin
    logic [127:0] rnd, exp_t;
    logic [7:0]   exp3;
    int           e, nxv, on3, found, nres;
    bit           stable, prev_xv;
    int           rises[$];

    rst_n = 1'b0; start = 1'b0; tt_ready = 1'b0;
    force_en = 1'b0; force_val = 1'b0; fn_tt = '0;
    start2 = 1'b0; rdy2 = 1'b0;

    #12;
    chk("rst_x", 128'(x), 128'd0);
    chk("rst_xvalid", 128'(x_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_tt", tt, 128'd0);
    chk("rst_onset", 128'(onset), 128'd0);
    chk("rst_ttvalid", 128'(tt_valid), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    fn_tt = model_tt(0, '0);
    run_sweep("x0", 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 64, 1'b1);
    fn_tt = model_tt(1, '0);
    run_sweep("and", {1'b1, 127'b0}, 1, 1'b1);
    fn_tt = model_tt(2, '0);
    run_sweep("ones", {128{1'b1}}, 128, 1'b1);
    for (int r = 0; r < 2; r++) begin
      rnd = rnd128();
      fn_tt = model_tt(4, rnd);
      run_sweep("rand", rnd, popc(rnd), 1'b1);
    end

    // Three-input instance behind a two-stage majority pipeline
    exp3 = '0; on3 = 0;
    for (int k = 0; k < 8; k++) begin
      exp3[k] = ($countones(3'(k)) >= 2);
      on3 += int'(exp3[k]);
    end
    e = 0; nxv = 0;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk);
    @(negedge clk); start2 = 1'b0;
    while (ttv2 !== 1'b1 && e < 50) begin
      if (xv2 === 1'b1) nxv++;
      @(negedge clk);
      e++;
    end
    chk("maj_latency", 128'(e), 128'd10);
    chk("maj_xvalid_cycles", 128'(nxv), 128'd8);
    chk("maj_tt", 128'(tt2), 128'(exp3));
    chk("maj_tt_const", 128'(tt2), 128'hE8);
    chk("maj_onset", 128'(on2), 128'(on3));
    rdy2 = 1'b1;
    @(negedge clk); rdy2 = 1'b0;
    chk("maj_valid_drop", 128'(ttv2), 128'd0);

    // Backpressure in DONE with f_in and start toggling
    rnd = rnd128();
    fn_tt = model_tt(4, rnd);
    run_sweep("bp", rnd, popc(rnd), 1'b0);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      force_en = 1'b1;
      force_val = 1'($urandom());
      start = 1'($urandom());
      @(negedge clk);
      if (tt !== rnd || onset !== 8'(popc(rnd)) || tt_valid !== 1'b1 ||
          x_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 128'(stable), 128'd1);
    start = 1'b1; tt_ready = 1'b1; force_en = 1'b0;
    @(negedge clk);
    start = 1'b0; tt_ready = 1'b0;
    chk("bp_accept_valid", 128'(tt_valid), 128'd0);
    chk("bp_accept_busy", 128'(busy), 128'd0);
    repeat (3) @(negedge clk);
    chk("bp_no_sweep_xv", 128'(x_valid), 128'd0);
    chk("bp_no_sweep_busy", 128'(busy), 128'd0);
    chk("bp_tt_kept", tt, rnd);
    rnd = rnd128();
    fn_tt = model_tt(4, rnd);
    run_sweep("after_bp", rnd, popc(rnd), 1'b1);

    // Reset in the middle of a sweep
    fn_tt = model_tt(0, '0);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (x === 7'd60) found = 1;
      else @(negedge clk);
    end
    chk("mid_found_x60", 128'(found), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 128'(x), 128'd0);
    chk("mid_rst_xvalid", 128'(x_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_tt", tt, 128'd0);
    chk("mid_rst_onset", 128'(onset), 128'd0);
    chk("mid_rst_ttvalid", 128'(tt_valid), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ttvalid", 128'(tt_valid), 128'd0);
    chk("post_rst_busy", 128'(busy), 128'd0);
    fn_tt = model_tt(3, '0);
    run_sweep("x6", {{64{1'b1}}, 64'h0}, 64, 1'b1);

    // Back-to-back sweeps with start and tt_ready held high
    rnd = rnd128();
    fn_tt = model_tt(4, rnd);
    exp_t = rnd;
    tt_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    prev_xv = 1'b0; nres = 0;
    for (int s = 0; s < 1000 && nres < 3; s++) begin
      @(negedge clk);
      if (x_valid === 1'b1 && !prev_xv) rises.push_back(s);
      prev_xv = (x_valid === 1'b1);
      if (tt_valid === 1'b1) begin
        chk("b2b_tt", tt, exp_t);
        chk("b2b_onset", 128'(onset), 128'(popc(exp_t)));
        nres++;
        rnd = rnd128();
        fn_tt = model_tt(4, rnd);
        exp_t = rnd;
      end
    end
    start = 1'b0;
    chk("b2b_results", 128'(nres), 128'd3);
    chk("b2b_starts", 128'(rises.size()), 128'd3);
    if (rises.size() >= 3) begin
      chk("b2b_gap1", 128'(rises[1] - rises[0]), 128'(TW + 2));
      chk("b2b_gap2", 128'(rises[2] - rises[1]), 128'(TW + 2));
    end
    @(negedge clk);
    tt_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
